// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and 74.25 MHz default timings for the PLL reset sequencer
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } pll_seq_state_t;

   localparam int DEF_RST_PULSE_CYCLES    = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 7425;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 742500;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer with synchronous active-high reset
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic m;

   always_ff @(posedge clk)
      if (rst) {q, m} <= 2'b00;
      else     {q, m} <= {m, d};

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, qualifies lock, holds core reset until lock is stable.
// Define PLL_SEQ_RELOCK_EN to re-sequence automatically on lock loss in RUN instead of faulting.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES         = 3,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic          refclk,
   input  logic          rst,
   input  logic          pll_locked,
   input  logic          restart,
   output logic          pll_rst,
   output logic          core_rst,
   output logic          ready,
   output logic          fault,
   output logic [RW-1:0] retries
);

   localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

   pll_seq_state_t state, state_n;
   logic [CW-1:0]  cnt, cnt_n, cnt_inc;
   logic [RW-1:0]  retries_n;
   logic           lock_s;

   sync_2ff u_lock_sync (
      .clk(refclk),
      .rst(rst),
      .d  (pll_locked),
      .q  (lock_s)
   );

   assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

   always_ff @(posedge refclk)
      if (rst) begin
         state   <= PLL_RST;
         cnt     <= '0;
         retries <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         retries <= retries_n;
      end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt_inc;
      retries_n = retries;
      if (restart) begin
         state_n   = PLL_RST;
         cnt_n     = '0;
         retries_n = '0;
      end else begin
         case (state)
            PLL_RST:
               if (cnt >= CW'(RST_PULSE_CYCLES - 1)) begin
                  state_n = WAIT_LOCK;
                  cnt_n   = '0;
               end
            WAIT_LOCK:
               if (lock_s) begin
                  state_n = STABLE;
                  cnt_n   = '0;
               end else if (cnt >= CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  cnt_n = '0;
                  if (retries < RW'(MAX_RETRIES)) begin
                     state_n   = PLL_RST;
                     retries_n = retries + RW'(1);
                  end else begin
                     state_n = FAULT;
                  end
               end
            STABLE:
               if (!lock_s) begin
                  state_n = WAIT_LOCK;
                  cnt_n   = '0;
               end else if (cnt >= CW'(LOCK_STABLE_CYCLES - 1)) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end
            RUN:
               if (!lock_s) begin
                  cnt_n = '0;
`ifdef PLL_SEQ_RELOCK_EN
                  state_n   = PLL_RST;
                  retries_n = '0;
`else
                  state_n = FAULT;
`endif
               end
            FAULT:
               cnt_n = cnt;
            default: begin
               state_n = PLL_RST;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Outputs decode straight from the state register, so they change only on clock edges
   always_comb begin
      pll_rst  = (state == PLL_RST) || (state == FAULT);
      core_rst = (state != RUN);
      ready    = (state == RUN);
      fault    = (state == FAULT);
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of pulse width, lock qualification, retries, fault and resets
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, core_rst, ready, fault;
   logic [1:0] retries;
   int         passed = 0;
   int         failed = 0;
   int         total = 0;
   int         n;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(20),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .restart   (restart),
      .pll_rst   (pll_rst),
      .core_rst  (core_rst),
      .ready     (ready),
      .fault     (fault),
      .retries   (retries)
   );

   always #5 refclk = ~refclk;

   task automatic step(input int k);
      repeat (k) @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts cycles until the selected output (0: pll_rst, 1: core_rst) reaches v, bounded
   task automatic until_val(input bit sel, input logic v, output int k);
      k = 0;
      while (((sel ? core_rst : pll_rst) !== v) && k < 200) begin
         step(1);
         k++;
      end
   endtask

   initial begin
      step(2);
      chk("reset_pll_rst", pll_rst, 1);
      chk("reset_core_rst", core_rst, 1);
      chk("reset_ready", ready, 0);
      chk("reset_fault", fault, 0);
      chk("reset_retries", retries, 0);

      rst = 1'b0;
      until_val(0, 1'b0, n);
      chk("clean_pulse_width", n, 4);
      step(10);
      pll_locked = 1'b1;
      until_val(1, 1'b0, n);
      chk("clean_lock_to_release", n, 11);
      chk("clean_ready", ready, 1);
      chk("clean_retries", retries, 0);
      chk("clean_pll_rst", pll_rst, 0);

      pll_locked = 1'b0;
      step(2);
      chk("runloss_ready_held", ready, 1);
      chk("runloss_core_rst_held", core_rst, 0);
      step(1);
      chk("runloss_core_rst", core_rst, 1);
      chk("runloss_ready", ready, 0);
`ifdef PLL_SEQ_RELOCK_EN
      chk("relock_fault", fault, 0);
      chk("relock_pll_rst", pll_rst, 1);
      until_val(0, 1'b0, n);
      chk("relock_pulse_width", n, 4);
      chk("relock_retries", retries, 0);
`else
      chk("runloss_fault", fault, 1);
      chk("runloss_pll_rst", pll_rst, 1);
      step(10);
      chk("runloss_fault_hold", fault, 1);
      chk("runloss_no_pulse", pll_rst, 1);
`endif

      restart = 1'b1;
      step(1);
      restart = 1'b0;
      chk("nolock_start_retries", retries, 0);
      chk("nolock_start_pll_rst", pll_rst, 1);
      for (int a = 0; a < 3; a++) begin
         until_val(0, 1'b0, n);
         chk($sformatf("nolock_pulse%0d", a), n, 4);
         chk($sformatf("nolock_retries%0d", a), retries, a);
         until_val(0, 1'b1, n);
         chk($sformatf("nolock_gap%0d", a), n, 20);
      end
      chk("nolock_fault", fault, 1);
      chk("nolock_core_rst", core_rst, 1);
      chk("nolock_retries_final", retries, 2);
      step(30);
      chk("nolock_fault_hold", fault, 1);
      chk("nolock_pll_rst_hold", pll_rst, 1);
      chk("nolock_core_rst_hold", core_rst, 1);

      restart = 1'b1;
      step(1);
      restart = 1'b0;
      chk("restart_fault", fault, 0);
      chk("restart_retries", retries, 0);
      chk("restart_pll_rst", pll_rst, 1);
      chk("restart_core_rst", core_rst, 1);

      until_val(0, 1'b0, n);
      chk("glitch_pulse_width", n, 4);
      pll_locked = 1'b1;
      step(6);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(2);
      chk("glitch_core_rst", core_rst, 1);
      chk("glitch_ready", ready, 0);
      chk("glitch_retries", retries, 0);
      until_val(1, 1'b0, n);
      chk("glitch_restarted_count", n, 9);

      restart = 1'b1;
      step(1);
      restart = 1'b0;
      until_val(0, 1'b0, n);
      chk("stable_pulse_width", n, 4);
      step(3);
      chk("stable_core_rst", core_rst, 1);
      chk("stable_pll_rst", pll_rst, 0);
      rst = 1'b1;
      step(1);
      chk("midrst_pll_rst", pll_rst, 1);
      chk("midrst_core_rst", core_rst, 1);
      chk("midrst_ready", ready, 0);
      chk("midrst_fault", fault, 0);
      chk("midrst_retries", retries, 0);
      rst = 1'b0;
      until_val(0, 1'b0, n);
      chk("midrst_pulse_width", n, 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the core clock PLL after power-up and on demand. It pulses the PLL reset, waits for a qualified lock, and holds the downstream core reset until lock has stayed stable. On a lock timeout it retries a bounded number of times and then flags a fault. It runs on the 74.25 MHz reference clock next to the PLL instance and drives the PLL `rst` input and the core-wide reset.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, default 16: PLL reset pulse width in `refclk` cycles; must be ≥1.
- `LOCK_STABLE_CYCLES`, default 7425: consecutive synchronized-lock cycles required before release (100 µs); must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, default 742500: maximum wait for first lock after the reset pulse (10 ms).
- `MAX_RETRIES`, default 3: PLL reset re-attempts after timeouts before FAULT.

Ports:
- `refclk` in 1: reference clock, sole clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`; asynchronous, synchronized internally.
- `restart` in 1: single-cycle request to re-sequence from any state.
- `pll_rst` out 1: PLL reset, active high.
- `core_rst` out 1: downstream core reset, active high.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retries` out $clog2(MAX_RETRIES+1): retry count of the current sequence.

## Operation
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT.
- PLL_RST: `pll_rst`=1; the counter counts `RST_PULSE_CYCLES`, then the block goes to WAIT_LOCK with the counter cleared.
- WAIT_LOCK: `pll_rst`=0.
  - Synchronized lock high → STABLE, counter cleared.
  - Counter reaching `LOCK_TIMEOUT_CYCLES`: if `retries` < `MAX_RETRIES`, increment `retries` and go to PLL_RST; otherwise go to FAULT.
- STABLE: counts consecutive synchronized-lock cycles.
  - Lock drops → back to WAIT_LOCK. The timeout counter restarts, and `retries` is unchanged.
  - `LOCK_STABLE_CYCLES` reached → RUN.
- RUN: `core_rst`=0 and `ready`=1. Lock loss behaviour is set by the macro under Configuration.
- FAULT: `pll_rst`=1 and `core_rst`=1; the block stays here until `rst` or `restart`.
- `core_rst`=1 in every state except RUN.
- `restart`: from any state, go to PLL_RST with the counter and `retries` cleared.
- `rst` has priority over `restart`.
- Counter width is $clog2 of the largest of the three cycle parameters, plus 1. The counter saturates and never wraps.

## Timing
- Reset values: state PLL_RST, `pll_rst`=1, `core_rst`=1, `ready`=0, `fault`=0, `retries`=0, sync flops 0, counter 0.
- All outputs are registered and decoded from the state register.
- `pll_locked` passes through a 2-flop synchronizer: a change reaches the FSM 2 cycles later.
- `pll_rst` is high for exactly `RST_PULSE_CYCLES` cycles per attempt.
- `core_rst` deasserts `LOCK_STABLE_CYCLES` + 1 cycles after the synchronized lock rises, provided lock holds.
- Lock loss in RUN: `core_rst` reasserts and `ready` falls on the cycle after the synchronized lock is seen low (3 cycles after the pin).
- `restart` in the same cycle as a timeout or a stable-count completion: `restart` wins.
- `rst` asserted mid-sequence: the block returns to reset values on the next edge, whatever the state.

## Configuration
- `PLL_SEQ_RELOCK_EN` defined: lock loss in RUN goes to PLL_RST with `retries` cleared (automatic re-sequence).
- Not defined: lock loss in RUN goes to FAULT, and only `rst` or `restart` recovers.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t`;
  - the default constants for pulse, stable and timeout cycles at 74.25 MHz.
- One sub-module, `sync_2ff`: a generic single-bit 2-flop synchronizer, used for `pll_locked`.
- FSM and counter live in `pll_reset_sequencer`.

## Test plan
Bench parameters for all scenarios: RST_PULSE=4, STABLE=8, TIMEOUT=20, MAX_RETRIES=2.
- Clean start: release `rst`, raise `pll_locked` 10 cycles after `pll_rst` falls.
  - Required: `pll_rst` high for 4 cycles.
  - Required: `core_rst` low exactly 2+8+1 cycles after the lock edge; `ready`=1; `retries`=0.
- Never lock: hold `pll_locked`=0.
  - Required: three 4-cycle `pll_rst` pulses 24 cycles apart; `retries` goes 0→1→2.
  - Required: then `fault`=1, `pll_rst`=1, `core_rst`=1, and these hold.
- Glitchy lock: in STABLE, drop lock for 1 cycle at stable count 5.
  - Required: return to WAIT_LOCK, the stable count restarts, `core_rst` stays 1, and `retries` is unchanged.
- Lock loss in RUN:
  - With `PLL_SEQ_RELOCK_EN`: `core_rst` reasserts 3 cycles after the pin drops, followed by a new 4-cycle `pll_rst` pulse.
  - Without it: `fault`=1 and no new `pll_rst` pulse.
- `restart` while in FAULT with `retries`=2: next cycle is PLL_RST, `retries`=0, `fault`=0.
- `rst` asserted in STABLE: next cycle all outputs are at their reset values.
